fpu_scheduler: RTL and testbench

Round-robin scheduler that shares one combinational half-precision FPU adder (operand A, operand B, result R) between N requesters. It accepts one operation at a time through a valid/ready handshake and registers the operands onto the FPU inputs. After a fixed settle time it captures the FPU result and returns it to the originating requester with a one-cycle response strobe. It sits between the requester-side datapath and the single FPU instance.

---
 rtl/fpu_scheduler.sv | 160 ++++++++++++++++
 tb/tb_fpu_scheduler.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_scheduler.sv
// Round-robin arbiter that time-shares one combinational fp16 adder between N requesters.
// Operands are registered onto the FPU, the result is sampled FPU_LAT cycles later and strobed back.
module fpu_scheduler #(
    parameter int unsigned N       = 4,
    parameter int unsigned FPU_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N-1:0]      req_valid,
    input  logic [16*N-1:0]   req_a,
    input  logic [16*N-1:0]   req_b,
    output logic [N-1:0]      req_ready,
    output logic [15:0]       fpu_asem,
    output logic [15:0]       fpu_bsem,
    input  logic [15:0]       fpu_rsem,
    output logic [N-1:0]      resp_valid,
    output logic [15:0]       resp_data,
    output logic              resp_exc,
    output logic              busy,
    output logic [15:0]       op_count
);

    localparam int unsigned DW = 16;
    localparam int unsigned PW = $clog2(N);
    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   grant_q, grant_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   asem_q, asem_d;
    logic [DW-1:0]   bsem_q, bsem_d;
    logic [DW-1:0]   resp_data_q, resp_data_d;
    logic            resp_exc_q, resp_exc_d;
    logic [N-1:0]    resp_valid_q, resp_valid_d;
    logic [DW-1:0]   op_count_q, op_count_d;
    logic            busy_q, busy_d;

    logic            gnt_found;
    logic [PW-1:0]   gnt_idx;
    int unsigned     srch_idx;
    logic [DW-1:0]   sel_a, sel_b;
    logic [N-1:0]    req_ready_c;

    // Cyclic first-set search starting at ptr
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        srch_idx  = 0;
        for (int unsigned k = 0; k < N; k++) begin
            srch_idx = 32'(ptr_q) + k;
            if (srch_idx >= N) begin
                srch_idx = srch_idx - N;
            end
            if (!gnt_found && req_valid[PW'(srch_idx)]) begin
                gnt_found = 1'b1;
                gnt_idx   = PW'(srch_idx);
            end
        end
    end

    // Operand mux for the granted requester
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (PW'(k) == gnt_idx) begin
                sel_a = req_a[k*DW +: DW];
                sel_b = req_b[k*DW +: DW];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        grant_d      = grant_q;
        cnt_d        = cnt_q;
        asem_d       = asem_q;
        bsem_d       = bsem_q;
        resp_data_d  = resp_data_q;
        resp_exc_d   = resp_exc_q;
        resp_valid_d = '0;
        op_count_d   = op_count_q;
        busy_d       = busy_q;
        req_ready_c  = '0;
        unique case (state_q)
            IDLE: begin
                if (gnt_found && !reset) begin
                    req_ready_c = N'(1) << gnt_idx;
                    asem_d      = sel_a;
                    bsem_d      = sel_b;
                    grant_d     = gnt_idx;
                    cnt_d       = CW'(FPU_LAT - 1);
                    busy_d      = 1'b1;
                    state_d     = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    resp_data_d  = fpu_rsem;
                    resp_exc_d   = &fpu_rsem[14:10];
                    resp_valid_d = N'(1) << grant_q;
                    state_d      = DONE;
                end
            end
            DONE: begin
                op_count_d = op_count_q + 1'b1;
                ptr_d      = (grant_q == PW'(N - 1)) ? '0 : grant_q + 1'b1;
                busy_d     = 1'b0;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            grant_q      <= '0;
            cnt_q        <= '0;
            asem_q       <= '0;
            bsem_q       <= '0;
            resp_data_q  <= '0;
            resp_exc_q   <= 1'b0;
            resp_valid_q <= '0;
            op_count_q   <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            grant_q      <= grant_d;
            cnt_q        <= cnt_d;
            asem_q       <= asem_d;
            bsem_q       <= bsem_d;
            resp_data_q  <= resp_data_d;
            resp_exc_q   <= resp_exc_d;
            resp_valid_q <= resp_valid_d;
            op_count_q   <= op_count_d;
            busy_q       <= busy_d;
        end
    end

    assign req_ready  = req_ready_c;
    assign fpu_asem   = asem_q;
    assign fpu_bsem   = bsem_q;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_exc   = resp_exc_q;
    assign busy       = busy_q;
    assign op_count   = op_count_q;

endmodule

// File: tb/tb_fpu_scheduler.sv
// Directed bench for fpu_scheduler: FPU_LAT=1 and FPU_LAT=4 instances, each with an fp16 adder model.
module tb_fpu_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_cmp = 0;
    int n_err = 0;

    // fp16 adder model built on double-precision arithmetic (normals, Inf/NaN, flush of tiny results)
    function automatic real h2r(input logic [15:0] h);
        logic [63:0] d;
        if (h[14:0] == 15'd0)
            d = {h[15], 63'd0};
        else if (h[14:10] == 5'h1F)
            d = {h[15], 11'h7FF, h[9:0], 42'd0};
        else
            d = {h[15], 11'(32'(h[14:10]) + 1008), h[9:0], 42'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [15:0] r2h(input real r);
        logic [63:0] d;
        int          e;
        int          he;
        logic [14:0] v;
        d = $realtobits(r);
        if (d[62:0] == 63'd0) return {d[63], 15'd0};
        e = 32'(d[62:52]);
        if (e == 2047) return {d[63], 5'h1F, (d[51:0] != 52'd0) ? 10'h200 : 10'h000};
        he = e - 1008;
        if (he >= 31) return {d[63], 15'h7C00};
        if (he <= 0) return {d[63], 15'd0};
        v = {5'(he), d[51:42]};
        if (d[41] && ((d[40:0] != 41'd0) || d[42])) v = v + 15'd1;
        return {d[63], v};
    endfunction

    function automatic logic [15:0] fp16_add(input logic [15:0] a, input logic [15:0] b);
        return r2h(h2r(a) + h2r(b));
    endfunction

    // Instance 1: FPU_LAT = 1
    logic        rst1;
    logic [3:0]  rv1, rr1, respv1;
    logic [63:0] ra1, rb1;
    logic [15:0] fa1, fb1, fr1, respd1, opc1;
    logic        respx1, busy1;

    fpu_scheduler #(.N(4), .FPU_LAT(1)) dut1 (
        .clk(clk), .reset(rst1), .req_valid(rv1), .req_a(ra1), .req_b(rb1),
        .req_ready(rr1), .fpu_asem(fa1), .fpu_bsem(fb1), .fpu_rsem(fr1),
        .resp_valid(respv1), .resp_data(respd1), .resp_exc(respx1),
        .busy(busy1), .op_count(opc1)
    );
    always_comb fr1 = fp16_add(fa1, fb1);

    // Instance 4: FPU_LAT = 4
    logic        rst4;
    logic [3:0]  rv4, rr4, respv4;
    logic [63:0] ra4, rb4;
    logic [15:0] fa4, fb4, fr4, respd4, opc4;
    logic        respx4, busy4;

    fpu_scheduler #(.N(4), .FPU_LAT(4)) dut4 (
        .clk(clk), .reset(rst4), .req_valid(rv4), .req_a(ra4), .req_b(rb4),
        .req_ready(rr4), .fpu_asem(fa4), .fpu_bsem(fb4), .fpu_rsem(fr4),
        .resp_valid(respv4), .resp_data(respd4), .resp_exc(respx4),
        .busy(busy4), .op_count(opc4)
    );
    always_comb fr4 = fp16_add(fa4, fb4);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    typedef struct packed {
        logic [1:0]  id;
        logic [15:0] r;
        logic        x;
    } exp_t;

    exp_t sb1[$];
    int   ops1 = 0;
    int   gnt_log[$];
    int   gnt_cyc[$];
    int   resp4_cnt = 0;
    logic [3:0] acc1 = '0;
    logic [3:0] acc4 = '0;

    function automatic int first_set(input logic [3:0] v);
        for (int i = 3; i >= 0; i--) if (v[i]) first_set = i;
    endfunction

    // Requesters drop req_valid after the edge at which req_ready was seen
    always @(posedge clk) begin
        #1;
        rv1 = rv1 & ~acc1;
        rv4 = rv4 & ~acc4;
        acc1 = '0;
        acc4 = '0;
        #7;
        acc1 = rst1 ? 4'd0 : (rr1 & rv1);
        acc4 = rst4 ? 4'd0 : (rr4 & rv4);
        if (acc1 != 4'd0) begin
            gnt_log.push_back(first_set(acc1));
            gnt_cyc.push_back(cyc);
        end
    end

    // Response scoreboard for instance 1
    always @(negedge clk) begin
        exp_t e;
        if (!rst1 && respv1 != 4'd0) begin
            if (sb1.size() == 0) begin
                chk("resp_unexpected", 32'(respv1), 32'd0);
            end else begin
                e = sb1.pop_front();
                chk("resp_id", 32'(respv1), 32'(4'b0001 << e.id));
                chk("resp_data", 32'(respd1), 32'(e.r));
                chk("resp_exc", 32'(respx1), 32'(e.x));
            end
        end
    end

    always @(negedge clk) if (respv4 != 4'd0) resp4_cnt++;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push1(input int id, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] r, input logic x);
        exp_t e;
        ra1[id*16 +: 16] = a;
        rb1[id*16 +: 16] = b;
        rv1[id] = 1'b1;
        e.id = 2'(id);
        e.r  = r;
        e.x  = x;
        sb1.push_back(e);
        ops1++;
    endtask

    task automatic wait_idle1(input int budget, input string tag);
        int k = 0;
        while ((sb1.size() != 0 || busy1 || rv1 != 4'd0) && k < budget) begin
            tick(1);
            k++;
        end
        chk(tag, 32'(sb1.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_rr[5];
        int exp_sk[3];
        int k;
        exp_rr = '{0, 1, 2, 3, 0};
        exp_sk = '{1, 0, 1};
        rst1 = 1'b1; rst4 = 1'b1;
        rv1 = '0; rv4 = '0; ra1 = '0; rb1 = '0; ra4 = '0; rb4 = '0;
        tick(3);
        chk("rst_ready", 32'(rr1), 32'd0);
        chk("rst_asem", 32'(fa1), 32'd0);
        chk("rst_bsem", 32'(fb1), 32'd0);
        chk("rst_resp_valid", 32'(respv1), 32'd0);
        chk("rst_resp_data", 32'(respd1), 32'd0);
        chk("rst_resp_exc", 32'(respx1), 32'd0);
        chk("rst_busy", 32'(busy1), 32'd0);
        chk("rst_op_count", 32'(opc1), 32'd0);
        rst1 = 1'b0; rst4 = 1'b0;
        tick(1);

        // Single operation, -0.75 + 0.25
        push1(0, 16'hBA00, 16'h3400, 16'hB800, 1'b0);
        #1;
        chk("single_ready", 32'(rr1), 32'h1);
        tick(1);
        chk("single_ready_drop", 32'(rr1), 32'd0);
        chk("single_busy", 32'(busy1), 32'd1);
        chk("single_asem", 32'(fa1), 32'hBA00);
        chk("single_bsem", 32'(fb1), 32'h3400);
        tick(1);
        chk("single_resp_valid", 32'(respv1), 32'h1);
        chk("single_resp_data", 32'(respd1), 32'hB800);
        chk("single_resp_exc", 32'(respx1), 32'd0);
        tick(1);
        chk("single_resp_drop", 32'(respv1), 32'd0);
        chk("single_busy_drop", 32'(busy1), 32'd0);
        chk("single_op_count", 32'(opc1), 32'd1);

        // Round-robin from a fresh pointer
        rst1 = 1'b1;
        tick(1);
        rst1 = 1'b0;
        ops1 = 0;
        gnt_log.delete();
        gnt_cyc.delete();
        push1(0, 16'h3C00, 16'h3C00, 16'h4000, 1'b0);
        push1(1, 16'h3C00, 16'h3800, 16'h3E00, 1'b0);
        push1(2, 16'h4000, 16'h4000, 16'h4400, 1'b0);
        push1(3, 16'h3800, 16'h3400, 16'h3A00, 1'b0);
        tick(1);
        push1(0, 16'h4200, 16'hC000, 16'h3C00, 1'b0);
        wait_idle1(60, "rr_drain");
        chk("rr_grant_count", 32'(gnt_log.size()), 32'd5);
        if (gnt_log.size() == 5) begin
            for (int i = 0; i < 5; i++) chk($sformatf("rr_grant%0d", i), 32'(gnt_log[i]), 32'(exp_rr[i]));
            for (int i = 1; i < 5; i++) chk($sformatf("rr_gap%0d", i), 32'(gnt_cyc[i] - gnt_cyc[i-1]), 32'd3);
        end
        chk("rr_op_count", 32'(opc1), 32'(ops1));

        // Pointer skip: after requester 1 completes, search starts at 2
        gnt_log.delete();
        gnt_cyc.delete();
        push1(1, 16'h3800, 16'h3800, 16'h3C00, 1'b0);
        wait_idle1(20, "skip_first_drain");
        push1(0, 16'h3400, 16'h3400, 16'h3800, 1'b0);
        push1(1, 16'h4400, 16'hBC00, 16'h4200, 1'b0);
        wait_idle1(30, "skip_drain");
        chk("skip_grant_count", 32'(gnt_log.size()), 32'd3);
        if (gnt_log.size() == 3) begin
            for (int i = 0; i < 3; i++) chk($sformatf("skip_grant%0d", i), 32'(gnt_log[i]), 32'(exp_sk[i]));
        end

        // Overflow to infinity sets the exception flag
        push1(2, 16'h7BFF, 16'h7BFF, 16'h7C00, 1'b1);
        wait_idle1(20, "exc_drain");
        chk("exc_flag_held", 32'(respx1), 32'd1);
        chk("exc_data_held", 32'(respd1), 32'h7C00);

        // op_count wrap
        chk("opc_before_preload", 32'(opc1), 32'(ops1));
        force dut1.op_count_q = 16'hFFFF;
        tick(1);
        release dut1.op_count_q;
        tick(1);
        chk("opc_preload", 32'(opc1), 32'hFFFF);
        push1(3, 16'h3C00, 16'h3C00, 16'h4000, 1'b0);
        wait_idle1(20, "wrap_drain");
        chk("opc_wrap", 32'(opc1), 32'd0);

        // FPU_LAT=4 latency and operand hold
        ra4[15:0] = 16'h3C00;
        rb4[15:0] = 16'h3800;
        rv4[0] = 1'b1;
        #1;
        chk("lat_ready", 32'(rr4), 32'h1);
        tick(1);
        ra4[15:0] = 16'hFFFF;
        rb4[15:0] = 16'hFFFF;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("lat_asem%0d", i), 32'(fa4), 32'h3C00);
            chk($sformatf("lat_bsem%0d", i), 32'(fb4), 32'h3800);
            chk($sformatf("lat_busy%0d", i), 32'(busy4), 32'd1);
            chk($sformatf("lat_no_resp%0d", i), 32'(respv4), 32'd0);
            tick(1);
        end
        chk("lat_resp_valid", 32'(respv4), 32'h1);
        chk("lat_resp_data", 32'(respd4), 32'h3E00);
        chk("lat_busy_done", 32'(busy4), 32'd1);
        tick(1);
        chk("lat_busy_drop", 32'(busy4), 32'd0);
        chk("lat_resp_drop", 32'(respv4), 32'd0);
        chk("lat_op_count", 32'(opc4), 32'd1);

        // Reset one cycle after acceptance aborts the operation
        ra4[15:0] = 16'h4000;
        rb4[15:0] = 16'h4000;
        rv4[0] = 1'b1;
        tick(1);
        chk("abort_busy", 32'(busy4), 32'd1);
        rst4 = 1'b1;
        tick(1);
        chk("abort_ready", 32'(rr4), 32'd0);
        chk("abort_asem", 32'(fa4), 32'd0);
        chk("abort_bsem", 32'(fb4), 32'd0);
        chk("abort_resp_valid", 32'(respv4), 32'd0);
        chk("abort_resp_data", 32'(respd4), 32'd0);
        chk("abort_resp_exc", 32'(respx4), 32'd0);
        chk("abort_busy_clr", 32'(busy4), 32'd0);
        chk("abort_op_count", 32'(opc4), 32'd0);
        rst4 = 1'b0;
        tick(6);
        chk("abort_no_resp", 32'(resp4_cnt), 32'd1);

        // Requester 0 resumes normally
        ra4[15:0] = 16'h4000;
        rb4[15:0] = 16'h4000;
        rv4[0] = 1'b1;
        k = 0;
        while (respv4 == 4'd0 && k < 20) begin
            tick(1);
            k++;
        end
        chk("resume_resp_valid", 32'(respv4), 32'h1);
        chk("resume_resp_data", 32'(respd4), 32'h4400);
        tick(2);
        chk("resume_op_count", 32'(opc4), 32'd1);
        chk("sb1_empty", 32'(sb1.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
